gray_codec: RTL and testbench
=============================

GRAY_CODEC -- requirements
Module: gray_codec

Interface
REQ-001 SHALL have parameter W, default 4, meaning code width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port in_valid  input  1  source presents a request this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts the request this cycle.
REQ-006 SHALL have port in_mode  input  2  operation: 00 bin->gray, 01 gray->bin, 10 gray increment, 11 gray decrement.
REQ-007 SHALL have port in_data  input  W  operand.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  sink accepts the result this cycle.
REQ-010 SHALL have port out_data  output  W  result.
REQ-011 SHALL have port out_wrap  output  1  increment/decrement crossed the all-ones/zero boundary.

Function
REQ-012 SHALL accept a request on any rising edge where in_valid and in_ready are both 1.
REQ-013 SHALL use a 2-stage pipeline: S1 registers the mode and the binary value of the operand (in_data for mode 00, gray->bin of in_data otherwise); S2 registers the final result.
REQ-014 SHALL compute gray->bin as a prefix XOR: b[W-1]=g[W-1], b[i]=b[i+1]^g[i].
REQ-015 SHALL compute bin->gray as g = b ^ (b>>1).
REQ-016 Mode 00 result SHALL be gray(in_data); mode 01 result SHALL be bin(in_data).
REQ-017 Mode 10 result SHALL be gray((bin(in_data)+1) mod 2^W); mode 11 result SHALL be gray((bin(in_data)-1) mod 2^W).
REQ-018 SHALL set out_wrap to 1 only for mode 10 with bin(in_data)=2^W-1, or mode 11 with bin(in_data)=0; otherwise 0.
REQ-019 Latency SHALL be exactly 2 cycles from acceptance to out_valid when out_ready is held 1.
REQ-020 Throughput SHALL be one request per cycle when out_ready is held 1.
REQ-021 S2 SHALL advance when S2 is empty or out_ready=1; S1 SHALL advance when S1 is empty or S2 advances.
REQ-022 in_ready SHALL equal "S1 empty or S1 advancing" and SHALL NOT depend combinationally on in_valid.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_wrap and out_valid SHALL hold stable.
REQ-024 No request SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-025 Simultaneous acceptance at input and delivery at output in one cycle SHALL both take effect.

Reset
REQ-026 Asserting rst SHALL immediately clear both stage valid flags, giving out_valid=0, out_data=0, out_wrap=0.
REQ-027 in_ready SHALL be 1 while rst is asserted and after it is released.
REQ-028 Reset mid-operation SHALL discard all in-flight requests; none SHALL appear after release.
REQ-029 The first acceptance after release SHALL occur no earlier than the first rising edge with rst=0.

Structure
REQ-030 A shared package SHALL hold the mode encodings (MODE_B2G=00, MODE_G2B=01, MODE_INC=10, MODE_DEC=11).
REQ-031 The W-bit combinational gray->bin converter SHALL be a sub-module named gray2bin_w, parameterised by W.
REQ-032 bin->gray and the +/-1 arithmetic SHALL be inline in gray_codec.

Verification (W=4)
REQ-033 Mode 00, in_data=1010, out_ready=1 -> out_data=1111 and out_wrap=0, 2 cycles later.
REQ-034 Mode 01 back-to-back inputs 1111, 1000, 1010 -> results 1010, 1111, 1100 on consecutive cycles.
REQ-035 Mode 10 with in_data=1000 (bin 15) -> out_data=0000, out_wrap=1; mode 11 with in_data=0000 -> out_data=1000, out_wrap=1.
REQ-036 Stream 8 requests while out_ready toggles pseudo-randomly -> all 8 results delivered in order, stable while stalled, in_ready=0 only when both stages are full and out_ready=0.
REQ-037 Assert rst with 2 requests in flight -> out_valid=0 immediately; no result appears after release; the next request completes normally.

Source files
------------

// File: rtl/gray_codec_pkg.sv
// Shared definitions for the gray code converter/counter pipeline.
package gray_codec_pkg;

    typedef enum logic [1:0] {
        MODE_B2G = 2'b00,
        MODE_G2B = 2'b01,
        MODE_INC = 2'b10,
        MODE_DEC = 2'b11
    } mode_t;

endpackage

// File: rtl/gray2bin_w.sv
// Combinational W-bit gray-to-binary converter (prefix XOR from the MSB down).
module gray2bin_w #(
    parameter int W = 4
) (
    input  logic [W-1:0] g,
    output logic [W-1:0] b
);

    always_comb begin
        b = g;
        for (int unsigned k = 1; k < W; k++) begin
            b[W-1-k] = b[W-k] ^ g[W-1-k];
        end
    end

endmodule

// File: rtl/gray_codec.sv
// Two-stage valid/ready pipeline: gray<->binary conversion and gray +/-1 stepping.
module gray_codec
    import gray_codec_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_wrap
);

    logic         s1_valid;
    mode_t        s1_mode;
    logic [W-1:0] s1_bin;

    logic         s2_valid;
    logic [W-1:0] s2_data;
    logic         s2_wrap;

    logic [W-1:0] in_bin;
    logic [W-1:0] step;
    logic [W-1:0] result;
    logic         wrap;
    logic         s1_adv;
    logic         s2_adv;

    gray2bin_w #(.W(W)) u_gray2bin (
        .g (in_data),
        .b (in_bin)
    );

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // S1 carries the operand already in binary so S2 only needs the +/-1 and re-encode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_B2G;
            s1_bin   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= mode_t'(in_mode);
                s1_bin  <= (mode_t'(in_mode) == MODE_B2G) ? in_data : in_bin;
            end
        end
    end

    always_comb begin
        step   = '0;
        result = '0;
        wrap   = 1'b0;
        case (s1_mode)
            MODE_B2G: result = s1_bin ^ (s1_bin >> 1);
            MODE_G2B: result = s1_bin;
            MODE_INC: begin
                step   = s1_bin + W'(1);
                result = step ^ (step >> 1);
                wrap   = &s1_bin;
            end
            MODE_DEC: begin
                step   = s1_bin - W'(1);
                result = step ^ (step >> 1);
                wrap   = ~|s1_bin;
            end
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_wrap  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= result;
                s2_wrap <= wrap;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_wrap  = s2_wrap;

endmodule

// File: tb/tb_gray_codec.sv
// Randomised scoreboard bench for gray_codec (W=4) against a reflected-gray table model.
module tb_gray_codec;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   in_mode = 2'b00;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_wrap;

    gray_codec #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_wrap  (out_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         wrap;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   gseq[N];
    int   binof[N];
    bit   rand_ready = 1'b0;
    logic ready_val = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) out_ready = rand_ready ? logic'($urandom_range(1, 0)) : ready_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reflected construction of the gray sequence: gseq[i] is the gray code of i.
    task automatic build_tables();
        gseq[0] = 0;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gseq[(1 << k) + i] = gseq[(1 << k) - 1 - i] | (1 << k);
            end
        end
        for (int i = 0; i < N; i++) binof[gseq[i]] = i;
    endtask

    function automatic exp_t model(input logic [1:0] m, input logic [W-1:0] d);
        exp_t e;
        int   v;
        v = binof[int'(d)];
        e.wrap = 1'b0;
        e.cyc  = 0;
        e.lat  = 1'b0;
        case (m)
            2'b00: e.data = W'(gseq[int'(d)]);
            2'b01: e.data = W'(v);
            2'b10: begin
                e.data = W'(gseq[(v + 1) % N]);
                e.wrap = (v == N - 1);
            end
            default: begin
                e.data = W'(gseq[(v + N - 1) % N]);
                e.wrap = (v == 0);
            end
        endcase
        return e;
    endfunction

    task automatic issue(input logic [1:0] m, input logic [W-1:0] d, input bit lat);
        int   n;
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        n = 0;
        #3;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #3;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
        end else begin
            e = model(m, d);
            e.cyc = cyc;
            e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Monitor: in_ready at +2 after negedge, outputs at +4 (edge at +5).
    initial begin
        bit           held = 1'b0;
        logic [W-1:0] hd = '0;
        logic         hw = 1'b0;
        exp_t         e;
        forever begin
            @(negedge clk);
            #2;
            check("in_ready", 32'(in_ready), 32'(!(sb.size() == 2 && !out_ready)));
            #2;
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(hd));
                check("stall_wrap", 32'(out_wrap), 32'(hw));
            end
            held = 1'b0;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else if (out_ready) begin
                    e = sb.pop_front();
                    check("data", 32'(out_data), 32'(e.data));
                    check("wrap", 32'(out_wrap), 32'(e.wrap));
                    if (e.lat) check("latency", 32'(cyc - e.cyc), 32'd2);
                end else begin
                    held = 1'b1;
                    hd   = out_data;
                    hw   = out_wrap;
                end
            end
        end
    end

    initial begin
        int n;
        build_tables();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_wrap", 32'(out_wrap), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;

        issue(2'b00, 4'b1010, 1'b1);
        idle(3);
        issue(2'b01, 4'b1111, 1'b1);
        issue(2'b01, 4'b1000, 1'b1);
        issue(2'b01, 4'b1010, 1'b1);
        idle(3);
        issue(2'b10, 4'b1000, 1'b1);
        issue(2'b11, 4'b0000, 1'b1);
        issue(2'b10, 4'b0110, 1'b1);
        issue(2'b11, 4'b0001, 1'b1);
        idle(4);

        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i >= 8 && $urandom_range(3, 0) == 0) idle(1);
            issue(2'($urandom_range(3, 0)), W'($urandom_range(N - 1, 0)), 1'b0);
        end
        idle(1);
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);

        ready_val = 1'b0;
        idle(1);
        issue(2'b00, 4'b0011, 1'b0);
        issue(2'b01, 4'b0101, 1'b0);
        idle(3);
        @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_out_wrap", 32'(out_wrap), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        ready_val = 1'b1;
        idle(6);
        issue(2'b11, 4'b0100, 1'b1);
        idle(5);
        check("final_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
